// File: rtl/trace_recorder.sv
// trace_recorder: samples {obs, data} every clock while capturing, run-length
// compresses the stream into 8-bit entries and holds them for readback.
// Sample entry = {1'b0, obs, data}; repeat entry = {1'b1, n}, n = 1..127.
module trace_recorder #(
    parameter int DW    = 6,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [DW-1:0] sample_in,
    input  logic          obs_in,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          full,
    output logic          overflow
);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DONE} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [6:0]  RUN_MAX = 7'd127;

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [6:0]    run_q, run_d;
    logic          first_q, first_d;
    logic          overflow_q, overflow_d;
    logic [DW:0]   last_q, last_d;
    logic [7:0]    rd_data_q;
    logic [7:0]    mem [DEPTH];

    logic [DW:0]   cur;
    logic [1:0]    nreq;
    logic [7:0]    req_a, req_b;
    logic [AW:0]   space;
    logic          wr0_en, wr1_en;
    logic [AW-1:0] wa0, wa1;

    assign cur   = {obs_in, sample_in};
    assign space = DEPTH_C - count_q;
    assign wa0   = count_q[AW-1:0];
    assign wa1   = wa0 + AW'(1);

    // Control state register; the trace memory itself is never reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            run_q      <= '0;
            first_q    <= 1'b0;
            overflow_q <= 1'b0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            run_q      <= run_d;
            first_q    <= first_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
        end
    end

    // Work out up to two entries per cycle, then commit only what fits.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        run_d      = run_q;
        first_d    = first_q;
        overflow_d = overflow_q;
        last_d     = last_q;
        nreq       = 2'd0;
        req_a      = 8'h00;
        req_b      = 8'h00;
        wr0_en     = 1'b0;
        wr1_en     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    count_d    = '0;
                    run_d      = '0;
                    overflow_d = 1'b0;
                    first_d    = 1'b1;
                    state_d    = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (stop) begin
                    state_d = S_FLUSH;
                end else if (first_q) begin
                    nreq    = 2'd1;
                    req_a   = {1'b0, cur};
                    last_d  = cur;
                    first_d = 1'b0;
                end else if (cur == last_q) begin
                    if (run_q != RUN_MAX) begin
                        run_d = run_q + 7'd1;
                    end else begin
                        // Saturated run: emit it and count this sample as the first of a new run.
                        nreq  = 2'd1;
                        req_a = {1'b1, RUN_MAX};
                        run_d = 7'd1;
                    end
                end else begin
                    if (run_q != 7'd0) begin
                        nreq  = 2'd2;
                        req_a = {1'b1, run_q};
                        req_b = {1'b0, cur};
                    end else begin
                        nreq  = 2'd1;
                        req_a = {1'b0, cur};
                    end
                    run_d  = '0;
                    last_d = cur;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
                run_d   = '0;
                if (run_q != 7'd0) begin
                    nreq  = 2'd1;
                    req_a = {1'b1, run_q};
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A write that does not fit ends the capture; earlier writes of the pair still land.
        if (nreq != 2'd0) begin
            if (space == '0) begin
                overflow_d = 1'b1;
                run_d      = '0;
                state_d    = S_DONE;
            end else begin
                wr0_en  = 1'b1;
                count_d = count_q + (AW+1)'(1);
                if (nreq == 2'd2) begin
                    if (space >= (AW+1)'(2)) begin
                        wr1_en  = 1'b1;
                        count_d = count_q + (AW+1)'(2);
                    end else begin
                        overflow_d = 1'b1;
                        run_d      = '0;
                        state_d    = S_DONE;
                    end
                end
            end
        end
    end

    // Trace memory: up to two consecutive entries written per cycle.
    always_ff @(posedge clock) begin
        if (wr0_en) mem[wa0] <= req_a;
        if (wr1_en) mem[wa1] <= req_b;
    end

    // Registered readback, gated by count so unwritten or stale entries read as zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= ({1'b0, rd_addr} < count_q) ? mem[rd_addr] : 8'h00;
        end
    end

    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign busy     = (state_q == S_CAPTURE) || (state_q == S_FLUSH);
    assign full     = (count_q == DEPTH_C);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_trace_recorder.sv
// Directed testbench for trace_recorder with hand-computed expected entries.
module tb_trace_recorder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [5:0] sample_in = '0;
    logic       obs_in = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic       busy, full, overflow;

    int checks = 0;
    int errors = 0;

    trace_recorder #(.DW(6), .DEPTH(16), .AW(4)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .sample_in(sample_in), .obs_in(obs_in), .rd_addr(rd_addr),
        .rd_data(rd_data), .count(count), .busy(busy), .full(full),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic [5:0] d, input logic o);
        sample_in = d;
        obs_in    = o;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        rd_addr = a;
        step();
        v = rd_data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    endtask

    task automatic test_reset_mid_capture();
        logic [7:0] v;
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy); end
        rd_addr = 4'd0;
        for (int i = 1; i <= 5; i++) put(6'(i), 1'b0);
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL mid_count5 got %0d want 5", count); end
        checks++; if (rd_data !== 8'h01) begin errors++; $display("FAIL mid_rd0 got %h want 01", rd_data); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_reset_count got %0d want 0", count); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mid_reset_rd got %h want 00", rd_data); end
        reset = 1'b0;
        step();
        do_start();
        put(6'h11, 1'b0);
        do_stop();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL restart_count got %0d want 1", count); end
        rd(4'd0, v);
        checks++; if (v !== 8'h11) begin errors++; $display("FAIL restart_entry0 got %h want 11", v); end
    endtask

    task automatic test_short_run();
        logic [7:0] v;
        logic [7:0] exp [3] = '{8'h05, 8'h82, 8'h09};
        do_start();
        put(6'h05, 1'b0); put(6'h05, 1'b0); put(6'h05, 1'b0); put(6'h09, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy got %b want 1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy got %b want 0", busy); end
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL short_count got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            rd(4'(i), v);
            checks++; if (v !== exp[i]) begin errors++; $display("FAIL short_entry%0d got %h want %h", i, v, exp[i]); end
        end
        rd(4'd7, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL rd_beyond_count got %h want 00", v); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL short_overflow got %b want 0", overflow); end
    endtask

    task automatic test_long_run();
        logic [7:0] v;
        logic [7:0] exp [3] = '{8'h7F, 8'hFF, 8'hC8};
        do_start();
        for (int i = 0; i < 200; i++) put(6'h3F, 1'b1);
        checks++; if (count !== 5'd2) begin errors++; $display("FAIL long_count_pre got %0d want 2", count); end
        do_stop();
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL long_count got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            rd(4'(i), v);
            checks++; if (v !== exp[i]) begin errors++; $display("FAIL long_entry%0d got %h want %h", i, v, exp[i]); end
        end
    endtask

    task automatic test_fill_alternate();
        logic [7:0] v;
        do_start();
        for (int i = 0; i < 20; i++) begin
            put((i % 2 == 1) ? 6'h02 : 6'h01, 1'b0);
            if (i == 15) begin
                checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count16 got %0d want 16", count); end
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %b want 0", overflow); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy got %b want 1", busy); end
            end
            if (i == 16) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b want 1", overflow); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_ovf_busy got %b want 0", busy); end
            end
        end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count_end got %0d want 16", count); end
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), v);
            checks++; if (v !== ((i % 2 == 1) ? 8'h02 : 8'h01)) begin errors++; $display("FAIL fill_entry%0d got %h want %h", i, v, (i % 2 == 1) ? 8'h02 : 8'h01); end
        end
    endtask

    task automatic test_start_in_done();
        do_start();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL restart_clear_count got %0d want 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL restart_clear_ovf got %b want 0", overflow); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", busy); end
        do_stop();
    endtask

    task automatic test_pair_overflow();
        logic [7:0] v;
        do_start();
        for (int i = 0; i < 15; i++) put((i % 2 == 1) ? 6'h02 : 6'h01, 1'b0);
        put(6'h01, 1'b0); put(6'h01, 1'b0); put(6'h01, 1'b0);
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL pair_count15 got %0d want 15", count); end
        put(6'h02, 1'b0);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL pair_count got %0d want 16", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL pair_ovf got %b want 1", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pair_busy got %b want 0", busy); end
        rd(4'd15, v);
        checks++; if (v !== 8'h83) begin errors++; $display("FAIL pair_entry15 got %h want 83", v); end
        rd(4'd14, v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL pair_entry14 got %h want 01", v); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_capture();
        test_short_run();
        test_long_run();
        test_fill_alternate();
        test_start_in_done();
        test_pair_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
